term_text_buffer: RTL and testbench
===================================

Name: term_text_buffer

Overview:
Character-cell text buffer between the UART receiver (char byte + one-cycle valid strobe) and the VGA character renderer. It interprets received bytes as terminal output: printable characters, CR, LF, backspace and form-feed. It maintains the cursor and a circular row offset for scrolling. It serves a registered random-access read port that the VGA pixel pipeline indexes by on-screen column/row.

Parameters:
COLS, 80, characters per row (640 px / 8 px glyph)
ROWS, 30, rows per screen (480 px / 16 px glyph)
CW, $clog2(COLS), column index width (7 at default)
RW, $clog2(ROWS), row index width (5 at default)
BLINK_CYCLES, 50_000_000, half-period of cursor blink in clk cycles (optional feature only)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
char_in  in  8  received byte from UART
char_valid  in  1  one-cycle strobe, char_in valid
rd_col  in  CW  VGA read column (screen coordinates)
rd_row  in  RW  VGA read row (screen coordinates)
rd_char  out  8  cell contents, 1-cycle read latency
rd_cursor  out  1  read cell is cursor and blink phase on (optional feature)
cursor_col  out  CW  current cursor column
cursor_row  out  RW  current cursor row (screen coordinates)
busy  out  1  FSM in CLEAR or SCROLL
overflow  out  1  sticky: byte dropped; cleared only by reset

Behaviour:
- Reset is asynchronous and active-low. Everything below is on rising clk.
- Reset values: cursor 0/0, top_row 0, hold register empty, overflow 0, rd_char 0x00, rd_cursor 0. The FSM enters CLEAR with busy=1.
- RAM contents are undefined until the first CLEAR completes.
- Input capture: one-entry hold register.
  - char_valid with hold empty: byte captured.
  - char_valid with hold full, and no dequeue in the same cycle: byte dropped, overflow set.
  - Dequeue and new strobe in the same cycle: new byte captured, no overflow.
- FSM states: CLEAR, IDLE, SCROLL.
- CLEAR:
  - Writes 0x20 to every physical cell, one per cycle, COLS*ROWS cycles.
  - Then: cursor 0/0, top_row 0, next state IDLE.
  - Hold register keeps capturing while in CLEAR.
- IDLE: when the hold register is full, dequeue and act in that cycle.
  - 0x20–0x7E: write the byte at (cursor_col, phys(cursor_row)); col+1.
    - If col was COLS-1: col 0 and advance row.
  - 0x0D (CR): col 0.
  - 0x0A (LF): col 0 and advance row (LF implies CR).
  - 0x08 (BS): if col>0, col-1 and write 0x20 at the new position. At col 0 there is no effect, and no reverse wrap.
  - 0x0C (FF): enter CLEAR.
  - All other codes are ignored and consumed in one cycle.
- Advance row:
  - If cursor_row<ROWS-1: row+1.
  - Otherwise: enter SCROLL with cursor_row held at ROWS-1.
- SCROLL:
  - top_row increments mod ROWS.
  - Physical row old_top (the new bottom) gets 0x20 written to all COLS cells, COLS cycles.
  - Then IDLE.
- Physical row mapping: phys(r) = (r + top_row) mod ROWS, computed by compare-and-subtract, never by a divider.
- Read port:
  - rd_char is registered: RAM[phys(rd_row)][rd_col] sampled on the edge after the address is presented. It is independent of the write port.
  - Read and write to the same cell in the same cycle returns the old data.
  - rd_col>=COLS or rd_row>=ROWS returns 0x20.
- Throughput: one printable byte per cycle in IDLE. UART byte rate (~1/10000 cycles) never overflows except during CLEAR (2400 cycles), at most one byte.

Optional Feature:
TERM_CURSOR_BLINK_EN
- Defined:
  - A blink counter toggles a phase bit every BLINK_CYCLES; reset phase is 1.
  - rd_cursor = 1, aligned with rd_char, when the registered read address equals (cursor_col, cursor_row) and the phase is 1.
  - The counter restarts with phase 1 on any cursor move, so the cursor is solid while typing.
- Not defined: rd_cursor is tied 0 and no counter is synthesised.

Decomposition:
- Package term_pkg:
  - Control-code constants CH_CR=8'h0D, CH_LF=8'h0A, CH_BS=8'h08, CH_FF=8'h0C, CH_SPACE=8'h20.
  - Printable range limits 8'h20/8'h7E.
  - FSM state encoding {CLEAR, IDLE, SCROLL}.
- One sub-module, term_char_ram:
  - Simple dual-port RAM, COLS*ROWS x 8, sync write, registered read.
  - Address = phys_row*COLS + col, inferred as BRAM.

Test Plan:
1. Release rst_n; hold char_valid low -> busy=1 for exactly 2400 cycles, then 0. Any cell reads 0x20; cursor 0/0.
2. Send 'A','B',0x0D,'C' -> cell(0,0)='C', cell(1,0)='B'; cursor_col=1, cursor_row=0.
3. Send 81 'x' bytes -> row 0 full of 'x', cell(0,1)='x'; cursor 1/1.
4. Fill rows 0–29 with row index, then send LF at row 29 -> busy for 80 cycles. Screen row 0 reads old row 1; row 29 all 0x20; cursor 0/29.
5. At col 0 send BS; then 'Q',BS -> first BS has no effect; cell(0,0)=0x20, cursor 0.
6. Send FF, then strobe 2 bytes during CLEAR -> first byte is processed after CLEAR, second dropped, overflow=1.

Source files
------------

// File: rtl/term_text_buffer_pkg.sv
// Shared constants and FSM encoding for the terminal text buffer.
package term_pkg;

    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        SCROLL = 2'd2
    } state_t;

endpackage

// File: rtl/term_text_buffer_if.sv
// UART-side byte input, VGA-side read port and status outputs of the text buffer.
interface term_text_buffer_if #(
    parameter int CW = 7,
    parameter int RW = 5
);
    logic [7:0]    char_in;
    logic          char_valid;
    logic [CW-1:0] rd_col;
    logic [RW-1:0] rd_row;
    logic [7:0]    rd_char;
    logic          rd_cursor;
    logic [CW-1:0] cursor_col;
    logic [RW-1:0] cursor_row;
    logic          busy;
    logic          overflow;

    modport master (
        output char_in, char_valid, rd_col, rd_row,
        input  rd_char, rd_cursor, cursor_col, cursor_row, busy, overflow
    );

    modport slave (
        input  char_in, char_valid, rd_col, rd_row,
        output rd_char, rd_cursor, cursor_col, cursor_row, busy, overflow
    );
endinterface

// File: rtl/term_char_ram.sv
// Simple dual-port character RAM: synchronous write, registered read (old data on collision).
module term_char_ram #(
    parameter int DEPTH = 2400,
    parameter int AW    = 12
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/term_text_buffer.sv
// Terminal text buffer: interprets UART bytes, tracks cursor and scroll offset, serves VGA reads.
// Define TERM_CURSOR_BLINK_EN to build the blinking cursor flag on rd_cursor.
//   state  | meaning
//   CLEAR  | writing space to every physical cell, then home cursor and scroll offset
//   IDLE   | consuming one held byte per cycle
//   SCROLL | advancing top_row and blanking the recycled physical row
module term_text_buffer
    import term_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CW           = $clog2(COLS),
    parameter int RW           = $clog2(ROWS),
    parameter int BLINK_CYCLES = 50_000_000
)(
    input logic              clk,
    input logic              rst_n,
    term_text_buffer_if.slave bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam logic [RW:0] ROWS_X = (RW+1)'(ROWS);

    state_t        state, state_nxt;
    logic [CW-1:0] cursor_col, col_nxt;
    logic [RW-1:0] cursor_row, row_nxt, top_row, top_nxt, scroll_row, scroll_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          hold_full, deq, overflow, advance;
    logic [7:0]    hold_data;
    logic          we;
    logic [AW-1:0] waddr, raddr;
    logic [7:0]    wdata, ram_rdata;
    logic          rd_oob, rd_init_q, rd_oob_q;

    // Screen-to-physical row by compare-and-subtract; r + t never exceeds 2*ROWS.
    function automatic logic [RW-1:0] phys(input logic [RW-1:0] r, input logic [RW-1:0] t);
        logic [RW:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= ROWS_X) s = s - ROWS_X;
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] pr, input logic [CW-1:0] c);
        return AW'(pr) * AW'(COLS) + AW'(c);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            overflow  <= 1'b0;
        end else if (bus.char_valid && (!hold_full || deq)) begin
            hold_full <= 1'b1;
            hold_data <= bus.char_in;
        end else begin
            if (deq) hold_full <= 1'b0;
            if (bus.char_valid) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            cursor_col <= '0;
            cursor_row <= '0;
            top_row    <= '0;
            scroll_row <= '0;
            cnt        <= AW'(CELLS - 1);
        end else begin
            state      <= state_nxt;
            cursor_col <= col_nxt;
            cursor_row <= row_nxt;
            top_row    <= top_nxt;
            scroll_row <= scroll_nxt;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        col_nxt    = cursor_col;
        row_nxt    = cursor_row;
        top_nxt    = top_row;
        scroll_nxt = scroll_row;
        cnt_nxt    = cnt;
        deq        = 1'b0;
        advance    = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = CH_SPACE;
        case (state)
            CLEAR: begin
                we      = 1'b1;
                waddr   = cnt;
                cnt_nxt = cnt - AW'(1);
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    col_nxt   = '0;
                    row_nxt   = '0;
                    top_nxt   = '0;
                end
            end
            SCROLL: begin
                we      = 1'b1;
                waddr   = cell_addr(scroll_row, CW'(cnt));
                cnt_nxt = cnt - AW'(1);
                if (cnt == '0) state_nxt = IDLE;
            end
            IDLE: begin
                if (hold_full) begin
                    deq = 1'b1;
                    if (hold_data >= CH_PRINT_LO && hold_data <= CH_PRINT_HI) begin
                        we    = 1'b1;
                        waddr = cell_addr(phys(cursor_row, top_row), cursor_col);
                        wdata = hold_data;
                        if (int'(cursor_col) == COLS - 1) begin
                            col_nxt = '0;
                            advance = 1'b1;
                        end else begin
                            col_nxt = cursor_col + CW'(1);
                        end
                    end else if (hold_data == CH_CR) begin
                        col_nxt = '0;
                    end else if (hold_data == CH_LF) begin
                        col_nxt = '0;
                        advance = 1'b1;
                    end else if (hold_data == CH_BS) begin
                        if (cursor_col != '0) begin
                            col_nxt = cursor_col - CW'(1);
                            we      = 1'b1;
                            waddr   = cell_addr(phys(cursor_row, top_row), cursor_col - CW'(1));
                        end
                    end else if (hold_data == CH_FF) begin
                        state_nxt = CLEAR;
                        cnt_nxt   = AW'(CELLS - 1);
                    end
                end
            end
            default: state_nxt = CLEAR;
        endcase
        // Bottom row: the old top physical row becomes the new, blank bottom row.
        if (advance) begin
            if (int'(cursor_row) != ROWS - 1) begin
                row_nxt = cursor_row + RW'(1);
            end else begin
                state_nxt  = SCROLL;
                cnt_nxt    = AW'(COLS - 1);
                scroll_nxt = top_row;
                top_nxt    = (int'(top_row) == ROWS - 1) ? '0 : top_row + RW'(1);
            end
        end
    end

    assign rd_oob = (int'(bus.rd_col) >= COLS) || (int'(bus.rd_row) >= ROWS);
    assign raddr  = rd_oob ? '0 : cell_addr(phys(bus.rd_row, top_row), bus.rd_col);

    term_char_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // RAM output has no reset, so the reset value of rd_char is forced here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_init_q <= 1'b1;
            rd_oob_q  <= 1'b0;
        end else begin
            rd_init_q <= 1'b0;
            rd_oob_q  <= rd_oob;
        end
    end

    assign bus.rd_char    = rd_init_q ? 8'h00 : (rd_oob_q ? CH_SPACE : ram_rdata);
    assign bus.cursor_col = cursor_col;
    assign bus.cursor_row = cursor_row;
    assign bus.busy       = (state != IDLE);
    assign bus.overflow   = overflow;

`ifdef TERM_CURSOR_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES);
    logic [BW-1:0] blink_cnt;
    logic          blink_phase, rd_cursor_q, moved;

    assign moved = (col_nxt != cursor_col) || (row_nxt != cursor_row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= BW'(BLINK_CYCLES - 1);
            blink_phase <= 1'b1;
            rd_cursor_q <= 1'b0;
        end else begin
            if (moved) begin
                blink_cnt   <= BW'(BLINK_CYCLES - 1);
                blink_phase <= 1'b1;
            end else if (blink_cnt == '0) begin
                blink_cnt   <= BW'(BLINK_CYCLES - 1);
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt - BW'(1);
            end
            rd_cursor_q <= (bus.rd_col == cursor_col) && (bus.rd_row == cursor_row) && blink_phase;
        end
    end

    assign bus.rd_cursor = rd_cursor_q;
`else
    localparam int unused_blink_cycles = BLINK_CYCLES;
    assign bus.rd_cursor = 1'b0;
`endif
endmodule

// File: tb/tb_term_text_buffer.sv
// Scoreboard bench for term_text_buffer: reads queue expected cells, a monitor checks rd_char.
module tb_term_text_buffer;
    import term_pkg::*;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    term_text_buffer_if #(.CW(7), .RW(5)) bus();

    term_text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    string      name_q [$];
    logic       rd_issue   = 1'b0;
    logic       rd_issue_d = 1'b0;

    always @(posedge clk) rd_issue_d <= rd_issue;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        string      nm;
        if (rd_issue_d) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: rd_char=%02h with empty scoreboard", bus.rd_char);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus.rd_char !== e) begin
                    n_fail++;
                    $display("FAIL %s: rd_char=%02h expected %02h", nm, bus.rd_char, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic read_cell(input int col, input int row, input logic [7:0] exp, input string name);
        bus.rd_col = 7'(col);
        bus.rd_row = 5'(row);
        rd_issue   = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.char_in    = b;
        bus.char_valid = 1'b1;
        @(negedge clk);
        bus.char_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_busy(input int window, output int cnt);
        cnt = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (bus.busy) cnt++;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({"wait_idle_", name}, int'(bus.busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        bus.rd_col     = '0;
        bus.rd_row     = '0;

        idle(3);
        check("reset_rd_char", int'(bus.rd_char), 0);
        check("reset_rd_cursor", int'(bus.rd_cursor), 0);
        check("reset_busy", int'(bus.busy), 1);
        check("reset_overflow", int'(bus.overflow), 0);
        check("reset_cursor_col", int'(bus.cursor_col), 0);
        check("reset_cursor_row", int'(bus.cursor_row), 0);

        // Initial clear
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_busy(2600, cnt);
        check("clear_busy_cycles", cnt, 2400);
        read_cell(5, 7, CH_SPACE, "clear_cell_5_7");
        read_cell(79, 29, CH_SPACE, "clear_cell_79_29");
        read_cell(80, 0, CH_SPACE, "oob_col_80");
        read_cell(0, 30, CH_SPACE, "oob_row_30");
        read_cell(127, 31, CH_SPACE, "oob_both");
        check("clear_cursor_col", int'(bus.cursor_col), 0);
        check("clear_cursor_row", int'(bus.cursor_row), 0);

        // A B CR C
        send_byte("A");
        send_byte("B");
        send_byte(CH_CR);
        send_byte("C");
        idle(3);
        read_cell(0, 0, "C", "cr_cell_0_0");
        read_cell(1, 0, "B", "cr_cell_1_0");
        check("cr_cursor_col", int'(bus.cursor_col), 1);
        check("cr_cursor_row", int'(bus.cursor_row), 0);
        check("b2b_no_overflow", int'(bus.overflow), 0);

        // Line wrap
        send_byte(CH_CR);
        for (int i = 0; i < 81; i++) send_byte("x");
        idle(3);
        read_cell(0, 0, "x", "wrap_cell_0_0");
        read_cell(79, 0, "x", "wrap_cell_79_0");
        read_cell(0, 1, "x", "wrap_cell_0_1");
        read_cell(1, 1, CH_SPACE, "wrap_cell_1_1");
        check("wrap_cursor_col", int'(bus.cursor_col), 1);
        check("wrap_cursor_row", int'(bus.cursor_row), 1);

        // Fill screen, then LF at the bottom row scrolls
        send_byte(CH_FF);
        idle(3);
        wait_idle(3000, "ff1");
        check("ff_cursor_col", int'(bus.cursor_col), 0);
        check("ff_cursor_row", int'(bus.cursor_row), 0);
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) send_byte(8'(8'h30 + r));
        for (int c = 0; c < COLS - 1; c++) send_byte(8'h4D);
        idle(3);
        check("fill_cursor_col", int'(bus.cursor_col), 79);
        check("fill_cursor_row", int'(bus.cursor_row), 29);
        read_cell(0, 29, 8'h4D, "fill_cell_0_29");
        read_cell(5, 1, 8'h31, "fill_cell_5_1");
        send_byte(CH_LF);
        count_busy(200, cnt);
        check("scroll_busy_cycles", cnt, 80);
        read_cell(0, 0, 8'h31, "scroll_cell_0_0");
        read_cell(79, 0, 8'h31, "scroll_cell_79_0");
        read_cell(0, 28, 8'h4D, "scroll_cell_0_28");
        read_cell(79, 28, CH_SPACE, "scroll_cell_79_28");
        read_cell(0, 29, CH_SPACE, "scroll_cell_0_29");
        read_cell(79, 29, CH_SPACE, "scroll_cell_79_29");
        check("scroll_cursor_col", int'(bus.cursor_col), 0);
        check("scroll_cursor_row", int'(bus.cursor_row), 29);

        // Backspace
        send_byte(CH_BS);
        idle(2);
        check("bs0_cursor_col", int'(bus.cursor_col), 0);
        check("bs0_cursor_row", int'(bus.cursor_row), 29);
        send_byte("Q");
        idle(2);
        check("q_cursor_col", int'(bus.cursor_col), 1);
        read_cell(0, 29, "Q", "q_cell_0_29");
        send_byte(CH_BS);
        idle(2);
        check("bs_cursor_col", int'(bus.cursor_col), 0);
        read_cell(0, 29, CH_SPACE, "bs_cell_0_29");

        // Bytes during CLEAR: first held, second dropped
        send_byte(CH_FF);
        idle(5);
        check("ff2_busy", int'(bus.busy), 1);
        send_byte("Z");
        idle(5);
        check("ff2_no_overflow_yet", int'(bus.overflow), 0);
        send_byte("Y");
        idle(2);
        check("ff2_overflow", int'(bus.overflow), 1);
        wait_idle(3000, "ff2");
        idle(3);
        check("ff2_cursor_col", int'(bus.cursor_col), 1);
        check("ff2_cursor_row", int'(bus.cursor_row), 0);
        read_cell(0, 0, "Z", "ff2_cell_0_0");
        read_cell(1, 0, CH_SPACE, "ff2_cell_1_0");
        read_cell(0, 29, CH_SPACE, "ff2_cell_0_29");
        check("ff2_overflow_sticky", int'(bus.overflow), 1);

        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
